// File: rtl/spi_slave_pkg.sv
// Shared constants and helpers for the SPI slave core: mode encodings,
// supported word width range and the edge classification type.
package spi_slave_pkg;

    // Mode encodings as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int MIN_WORD_W = 4;
    localparam int MAX_WORD_W = 32;

    // What a detected SCK transition means for the shifters
    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_SAMPLE,
        EDGE_SHIFT
    } spi_edge_e;

    // Modes 0 and 3 capture MOSI on the rising SCK edge, modes 1 and 2 on the falling one
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        logic [1:0] mode;
        mode = {cpol, cpha};
        return (mode == MODE0) || (mode == MODE3);
    endfunction

endpackage

// File: rtl/spi_slave_core_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin followed by a rise/fall
// detector built from the last two synchronised samples.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchroniser and keep one older sample for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave transceiver with oversampled pins, any CPOL/CPHA, any word width,
// a single-entry transmit holding register and frame start/end strobes.
// Optional build macro: SPI_SLAVE_CORE_LSB_FIRST_EN selects LSB-first shifting
// in both directions; without it both directions are MSB first.
module spi_slave_core
    import spi_slave_pkg::*;
#(
    parameter int                WORD_W        = 8,
    parameter bit                CPOL          = 1'b0,
    parameter bit                CPHA          = 1'b0,
    parameter int                SYNC_STAGES   = 2,
    parameter logic [WORD_W-1:0] UNDERRUN_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              mosi,
    input  logic              ss_n,
    output logic              miso,
    output logic              miso_oe,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              frame_start,
    output logic              frame_end
);

    localparam int          CNT_W       = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [1:0]  MODE        = {CPOL, CPHA};
    localparam bit          SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
    localparam bit          SHIFT_RISE  = (MODE == MODE1) || (MODE == MODE2);

    if (WORD_W < MIN_WORD_W || WORD_W > MAX_WORD_W) begin : g_bad_word_w
        $error("spi_slave_core: WORD_W must be within 4..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("spi_slave_core: SYNC_STAGES must be 2 or 3");
    end

    logic sck_level_unused;
    logic sck_rise;
    logic sck_fall;
    logic sel_level;
    logic sel_rise;
    logic sel_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_s;

    spi_edge_e         edge_kind;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] rx_shreg;
    logic [WORD_W-1:0] rx_next;
    logic [WORD_W-1:0] tx_shreg;
    logic [WORD_W-1:0] tx_shifted;
    logic [WORD_W-1:0] hold_data;
    logic              hold_full;
    logic              load_evt;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sck),
        .level (sck_level_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // Select is synchronised in its active-high form so a reset synchroniser reads as "not selected"
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (~ss_n),
        .level (sel_level),
        .rise  (sel_rise),
        .fall  (sel_fall)
    );

    // MOSI goes through a plain synchroniser of equal depth so it lines up with the SCK samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_q[SYNC_STAGES-1];

    // Classify each SCK transition seen while selected as a sample or a shift edge
    always_comb begin
        edge_kind = EDGE_NONE;
        if (sel_level) begin
            if (SAMPLE_RISE ? sck_rise : sck_fall) begin
                edge_kind = EDGE_SAMPLE;
            end else if (SHIFT_RISE ? sck_rise : sck_fall) begin
                edge_kind = EDGE_SHIFT;
            end
        end
    end

`ifdef SPI_SLAVE_CORE_LSB_FIRST_EN
    assign rx_next    = {mosi_s, rx_shreg[WORD_W-1:1]};
    assign tx_shifted = {1'b0, tx_shreg[WORD_W-1:1]};
    assign miso       = tx_shreg[0];
`else
    assign rx_next    = {rx_shreg[WORD_W-2:0], mosi_s};
    assign tx_shifted = {tx_shreg[WORD_W-2:0], 1'b0};
    assign miso       = tx_shreg[WORD_W-1];
`endif

    assign load_evt = (sel_rise && !CPHA) || (edge_kind == EDGE_SHIFT && bit_cnt == '0);
    assign tx_ready = ~hold_full;

    // Frame strobes and pad enable follow the synchronised select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            miso_oe     <= 1'b0;
        end else begin
            frame_start <= sel_rise;
            frame_end   <= sel_fall;
            miso_oe     <= sel_level;
        end
    end

    // Receive path: count sample edges, collect bits and publish each complete word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            rx_shreg <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (sel_rise || sel_fall) begin
                bit_cnt <= '0;
            end else if (edge_kind == EDGE_SAMPLE) begin
                rx_shreg <= rx_next;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt  <= '0;
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    // Transmit path: load from the holding register (or underrun) at word boundaries, shift otherwise;
    // a write landing on a load cycle is stored after the load has taken the old content
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shreg    <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (load_evt) begin
                tx_shreg    <= hold_full ? hold_data : UNDERRUN_WORD;
                tx_underrun <= ~hold_full;
                hold_full   <= 1'b0;
            end else if (edge_kind == EDGE_SHIFT) begin
                tx_shreg <= tx_shifted;
            end
            if (tx_valid && !hold_full) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: four 8-bit instances (modes 0..3) and one 16-bit
// mode-1 instance with three-stage synchronisers, driven by a bit-banged master.
`timescale 1ns/1ps
module tb_spi_slave_core;

    localparam int HALF = 6;
    localparam int NI   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck_base = 1'b0;
    logic mosi = 1'b0;
    logic [NI-1:0] ss_n = '1;
    logic [NI-1:0] tx_valid = '0;
    logic [7:0]  tx_data8 = '0;
    logic [15:0] tx_data16 = '0;

    logic [NI-1:0] miso, miso_oe, rx_valid, tx_ready, tx_underrun, frame_start, frame_end;
    logic [7:0]  rx_data8 [4];
    logic [15:0] rx_data16;

    int checks = 0;
    int errors = 0;
    int rxv_cnt [NI] = '{default: 0};
    int und_cnt [NI] = '{default: 0};
    int fs_cnt  [NI] = '{default: 0};
    int fe_cnt  [NI] = '{default: 0};
    logic [15:0] last_rx [NI] = '{default: '0};

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_w8
            logic sck_pin;
            assign sck_pin = sck_base ^ (g >= 2);
            spi_slave_core #(
                .WORD_W(8), .CPOL(g >= 2), .CPHA(g % 2 == 1),
                .SYNC_STAGES(2), .UNDERRUN_WORD(8'h5A)
            ) u_dut (
                .clk(clk), .rst_n(rst_n), .sck(sck_pin), .mosi(mosi), .ss_n(ss_n[g]),
                .miso(miso[g]), .miso_oe(miso_oe[g]), .rx_data(rx_data8[g]), .rx_valid(rx_valid[g]),
                .tx_data(tx_data8), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
                .tx_underrun(tx_underrun[g]), .frame_start(frame_start[g]), .frame_end(frame_end[g])
            );
        end
    endgenerate

    spi_slave_core #(
        .WORD_W(16), .CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(3), .UNDERRUN_WORD(16'hBEEF)
    ) u_dut16 (
        .clk(clk), .rst_n(rst_n), .sck(sck_base), .mosi(mosi), .ss_n(ss_n[4]),
        .miso(miso[4]), .miso_oe(miso_oe[4]), .rx_data(rx_data16), .rx_valid(rx_valid[4]),
        .tx_data(tx_data16), .tx_valid(tx_valid[4]), .tx_ready(tx_ready[4]),
        .tx_underrun(tx_underrun[4]), .frame_start(frame_start[4]), .frame_end(frame_end[4])
    );

    // Strobe monitor: counts every one-cycle pulse and remembers the last received word
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rx_valid[i]) begin
                rxv_cnt[i]++;
                if (i == 4) last_rx[i] = rx_data16;
                else        last_rx[i] = {8'h00, rx_data8[i]};
            end
            if (tx_underrun[i]) und_cnt[i]++;
            if (frame_start[i]) fs_cnt[i]++;
            if (frame_end[i])   fe_cnt[i]++;
        end
    end

    // Reference model of bit order: the master is always MSB first on the wire
    function automatic logic [15:0] wire_order(input logic [15:0] v, input int w);
`ifdef SPI_SLAVE_CORE_LSB_FIRST_EN
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[w-1-i] = v[i];
        return r;
`else
        if (w == 8) return {8'h00, v[7:0]};
        return v;
`endif
    endfunction

    typedef struct {
        int         idx;
        bit         preload;
        logic [7:0] tx;
        logic [7:0] mosi_w;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_und;
    } vec_t;

    function automatic vec_t make_vec(input int idx, input bit pre, input logic [7:0] tx, input logic [7:0] mw);
        vec_t v;
        logic [15:0] t;
        v.idx = idx; v.preload = pre; v.tx = tx; v.mosi_w = mw;
        t = wire_order({8'h00, mw}, 8);
        v.exp_rx = t[7:0];
        t = wire_order({8'h00, pre ? tx : 8'h5A}, 8);
        v.exp_miso = t[7:0];
        // loads per one-word frame: CPHA=0 loads at frame start and after the word, CPHA=1 once
        v.exp_und = ((idx % 2 == 0) ? 2 : 1) - (pre ? 1 : 0);
        return v;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic write_tx(input int idx, input logic [15:0] word);
        int n;
        n = 0;
        tx_data8  = word[7:0];
        tx_data16 = word;
        tx_valid[idx] = 1'b1;
        @(negedge clk);
        while (!tx_ready[idx] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("[TB] FAIL tx_accept_timeout: got ready 0 expected 1");
        end
        @(posedge clk);
        #1;
        tx_valid[idx] = 1'b0;
        check_output("tx_ready_after_write", tx_ready[idx], 1'b0);
    endtask

    task automatic frame_open(input int idx);
        ss_n[idx] = 1'b0;
        wait_clks(10);
    endtask

    task automatic frame_close(input int idx);
        wait_clks(HALF);
        ss_n[idx] = 1'b1;
        wait_clks(12);
    endtask

    task automatic xfer_word(input int idx, input int w, input bit cpha, input int nbits,
                             input logic [15:0] dout, output logic [15:0] din);
        din = '0;
        for (int b = 0; b < nbits; b++) begin
            if (!cpha) begin
                mosi = dout[w-1-b];
                wait_clks(HALF);
                din = {din[14:0], miso[idx]};
                sck_base = 1'b1;
                wait_clks(HALF);
                sck_base = 1'b0;
            end else begin
                sck_base = 1'b1;
                mosi = dout[w-1-b];
                wait_clks(HALF);
                din = {din[14:0], miso[idx]};
                sck_base = 1'b0;
                wait_clks(HALF);
            end
        end
    endtask

    task automatic apply_stimulus(input vec_t v, output logic [7:0] got_miso,
                                  output int d_rxv, output int d_und, output int d_fs, output int d_fe);
        int r0, u0, s0, e0;
        logic [15:0] din;
        if (v.preload) write_tx(v.idx, {8'h00, v.tx});
        r0 = rxv_cnt[v.idx]; u0 = und_cnt[v.idx]; s0 = fs_cnt[v.idx]; e0 = fe_cnt[v.idx];
        frame_open(v.idx);
        xfer_word(v.idx, 8, v.idx % 2 == 1, 8, {8'h00, v.mosi_w}, din);
        frame_close(v.idx);
        got_miso = din[7:0];
        d_rxv = rxv_cnt[v.idx] - r0; d_und = und_cnt[v.idx] - u0;
        d_fs = fs_cnt[v.idx] - s0;   d_fe = fe_cnt[v.idx] - e0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] got;
        int d_rxv, d_und, d_fs, d_fe;
        apply_stimulus(v, got, d_rxv, d_und, d_fs, d_fe);
        check_output($sformatf("miso_word_i%0d", v.idx), got, v.exp_miso);
        check_output($sformatf("rx_data_i%0d", v.idx), last_rx[v.idx], {8'h00, v.exp_rx});
        check_output($sformatf("rx_valid_count_i%0d", v.idx), d_rxv, 1);
        check_output($sformatf("underrun_count_i%0d", v.idx), d_und, v.exp_und);
        check_output($sformatf("frame_start_count_i%0d", v.idx), d_fs, 1);
        check_output($sformatf("frame_end_count_i%0d", v.idx), d_fe, 1);
    endtask

    task automatic check_reset_outputs(input int i, input string tag);
        check_output({tag, "_outputs"},
                     {miso[i], miso_oe[i], rx_valid[i], tx_ready[i], tx_underrun[i], frame_start[i], frame_end[i]},
                     7'b0001000);
        if (i == 4) check_output({tag, "_rx_data"}, rx_data16, 16'h0);
        else        check_output({tag, "_rx_data"}, rx_data8[i], 8'h0);
    endtask

    initial begin
        vec_t vecs [4];
        vec_t rv;
        logic [15:0] w16 [3];
        logic [15:0] din;
        logic [15:0] cap [3];
        logic [7:0]  c1, c2;
        int r0, u0, e0, s0;

        $display("[TB] start");
        wait_clks(3);
        for (int i = 0; i < NI; i++) check_reset_outputs(i, "reset");
        rst_n = 1'b1;
        wait_clks(30);
        for (int i = 0; i < NI; i++) begin
            check_output("idle_strobes", rxv_cnt[i] + und_cnt[i] + fs_cnt[i] + fe_cnt[i], 0);
            check_output("idle_tx_ready", tx_ready[i], 1'b1);
        end

        // Table: mode 0 with a preloaded reply, then modes 1..3 exchanging 0xC3
        vecs[0] = make_vec(0, 1'b1, 8'h3C, 8'hA5);
        vecs[1] = make_vec(1, 1'b1, 8'hC3, 8'hC3);
        vecs[2] = make_vec(2, 1'b1, 8'hC3, 8'hC3);
        vecs[3] = make_vec(3, 1'b1, 8'hC3, 8'hC3);
        for (int k = 0; k < 4; k++) run_vec(vecs[k]);

        // Randomised single-word frames against the model
        for (int k = 0; k < 12; k++) begin
            rv = make_vec($urandom_range(0, 3), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            run_vec(rv);
        end

        // 16-bit, three words, only the first one supplied
        for (int k = 0; k < 3; k++) w16[k] = 16'($urandom);
        write_tx(4, 16'h1234);
        r0 = rxv_cnt[4]; u0 = und_cnt[4];
        frame_open(4);
        for (int k = 0; k < 3; k++) begin
            xfer_word(4, 16, 1'b1, 16, w16[k], din);
            cap[k] = din;
        end
        frame_close(4);
        check_output("w16_word1", cap[0], wire_order(16'h1234, 16));
        check_output("w16_word2", cap[1], wire_order(16'hBEEF, 16));
        check_output("w16_word3", cap[2], wire_order(16'hBEEF, 16));
        check_output("w16_rx_last", last_rx[4], wire_order(w16[2], 16));
        check_output("w16_rx_valid_count", rxv_cnt[4] - r0, 3);
        check_output("w16_underrun_count", und_cnt[4] - u0, 2);

        // ss_n raised after five bits discards the partial word
        r0 = rxv_cnt[0]; e0 = fe_cnt[0];
        frame_open(0);
        xfer_word(0, 8, 1'b0, 5, 16'h00F7, din);
        frame_close(0);
        check_output("abort_rx_valid_count", rxv_cnt[0] - r0, 0);
        check_output("abort_frame_end_count", fe_cnt[0] - e0, 1);
        run_vec(make_vec(0, 1'b0, 8'h00, 8'h81));

        // Write waiting on a full holding register lands right after the first load
        write_tx(1, 16'h0096);
        u0 = und_cnt[1];
        fork
            begin
                frame_open(1);
                xfer_word(1, 8, 1'b1, 8, 16'h0011, din); c1 = din[7:0];
                xfer_word(1, 8, 1'b1, 8, 16'h0022, din); c2 = din[7:0];
                frame_close(1);
            end
            write_tx(1, 16'h0069);
        join
        check_output("coincide_word1", c1, wire_order(16'h0096, 8));
        check_output("coincide_word2", c2, wire_order(16'h0069, 8));
        check_output("coincide_underruns", und_cnt[1] - u0, 0);
        check_output("coincide_rx_last", last_rx[1], wire_order(16'h0022, 8));

        // Reset asserted mid-frame clears outputs at once and emits no strobes
        frame_open(0);
        xfer_word(0, 8, 1'b0, 3, 16'h00FF, din);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(0, "midframe_reset");
        ss_n[0] = 1'b1;
        sck_base = 1'b0;
        wait_clks(5);
        s0 = fs_cnt[0]; e0 = fe_cnt[0]; r0 = rxv_cnt[0];
        rst_n = 1'b1;
        wait_clks(20);
        check_output("post_reset_strobes", (fs_cnt[0] - s0) + (fe_cnt[0] - e0) + (rxv_cnt[0] - r0), 0);
        run_vec(make_vec(0, 1'b1, 8'h01, 8'h01));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
